alu_bus_control: RTL and testbench

Control-and-datapath core of the 8-bit accumulator CPU. It combines three functions: the instruction-sequencing control unit, the 8-to-1 system bus multiplexer, and the accumulator ALU. It drives every load, clear and increment strobe of the external AR, PC, DR, AC, IR and TR registers, the memory read/write strobes, and the bus and ALU data paths. Memory is 16×8 and is addressed by the 4-bit AR.

---
 rtl/alu_bus_control.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_bus_control.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bus_control.sv
// alu_bus_control: sequencing FSM, 8-to-1 system bus mux and accumulator ALU of the 8-bit accumulator CPU.
// Latency: strobes are registered and are valid for the entire state they belong to; bus_out/alu_result/alu_e are combinational.
// Backpressure: none; the sequencer advances one state per clock until HALT, and only reset leaves HALT.
//
// Ports:
//   clock, reset (asynchronous, active-low; forces INIT)
//   ir, ac, dr, tr, x_data, memory_data (8b), ar, pc (4b) : register and memory values
//   bus_out, alu_result, alu_e                            : datapath outputs
//   load_*, clear_*, inc_*, memory_read/write             : register and memory strobes
//   bus_selectors, alu_enable, alu_mode                   : datapath control
// Build option: define SHIFT_OPS_EN to give opcodes 9/A (SHR/SHL) and ALU modes 100/101 their shift behaviour.
module alu_bus_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic [7:0] ac,
  input  logic [7:0] dr,
  input  logic [7:0] tr,
  input  logic [7:0] x_data,
  input  logic [7:0] memory_data,
  input  logic [3:0] ar,
  input  logic [3:0] pc,
  output logic [7:0] bus_out,
  output logic [7:0] alu_result,
  output logic       alu_e,
  output logic       load_ar,
  output logic       load_pc,
  output logic       load_dr,
  output logic       load_ac,
  output logic       load_ir,
  output logic       load_tr,
  output logic       clear_ar,
  output logic       clear_pc,
  output logic       clear_dr,
  output logic       clear_ac,
  output logic       clear_tr,
  output logic       inc_ar,
  output logic       inc_pc,
  output logic       inc_dr,
  output logic       inc_ac,
  output logic       inc_tr,
  output logic       memory_read,
  output logic       memory_write,
  output logic [2:0] bus_selectors,
  output logic       alu_enable,
  output logic [2:0] alu_mode
);

  typedef enum logic [2:0] {S_INIT, S_T0, S_T1, S_T2, S_T3, S_T4, S_HALT} state_t;

  typedef struct packed {
    logic       load_ar, load_pc, load_dr, load_ac, load_ir, load_tr;
    logic       clear_ar, clear_pc, clear_dr, clear_ac, clear_tr;
    logic       inc_ar, inc_pc, inc_dr, inc_ac, inc_tr;
    logic       memory_read, memory_write;
    logic [2:0] bus_sel;
    logic       alu_enable;
    logic [2:0] alu_mode;
  } ctrl_t;

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [3:0] opcode;
  logic       ir_addr_unused;

  assign opcode         = ir[7:4];
  assign ir_addr_unused = ^ir[3:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        case (opcode)
          4'h0, 4'h1, 4'h2: state_d = S_T4;
          4'hF:             state_d = S_HALT;
          default:          state_d = S_T0;
        endcase
      end
      S_T4:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
  end

  // Strobes are decoded for the state being entered so that the registered
  // copy lines up with that state. ir is already stable when T2 and T3 end.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_INIT: begin
        ctrl_d.clear_ar = 1'b1;
        ctrl_d.clear_pc = 1'b1;
        ctrl_d.clear_dr = 1'b1;
        ctrl_d.clear_ac = 1'b1;
        ctrl_d.clear_tr = 1'b1;
      end
      S_T0: begin
        ctrl_d.bus_sel = 3'd2;
        ctrl_d.load_ar = 1'b1;
      end
      S_T1: begin
        ctrl_d.memory_read = 1'b1;
        ctrl_d.bus_sel     = 3'd7;
        ctrl_d.load_ir     = 1'b1;
        ctrl_d.inc_pc      = 1'b1;
      end
      S_T2: begin
        ctrl_d.bus_sel = 3'd5;
        ctrl_d.load_ar = 1'b1;
      end
      S_T3: begin
        case (opcode)
          4'h0, 4'h1, 4'h2: begin
            ctrl_d.memory_read = 1'b1;
            ctrl_d.bus_sel     = 3'd7;
            ctrl_d.load_dr     = 1'b1;
          end
          4'h3: begin
            ctrl_d.bus_sel      = 3'd4;
            ctrl_d.memory_write = 1'b1;
          end
          4'h4: begin
            ctrl_d.bus_sel = 3'd1;
            ctrl_d.load_pc = 1'b1;
          end
          4'h6: ctrl_d.clear_ac = 1'b1;
          4'h7: begin
            ctrl_d.alu_enable = 1'b1;
            ctrl_d.alu_mode   = 3'b011;
            ctrl_d.load_ac    = 1'b1;
          end
          4'h8: ctrl_d.inc_ac = 1'b1;
`ifdef SHIFT_OPS_EN
          4'h9, 4'hA: begin
            // The ALU must be enabled or it would just pass ac through.
            ctrl_d.alu_enable = 1'b1;
            ctrl_d.alu_mode   = (opcode == 4'h9) ? 3'b100 : 3'b101;
            ctrl_d.load_ac    = 1'b1;
          end
`endif
          default: ctrl_d = '0;
        endcase
      end
      S_T4: begin
        // Only AND/ADD/LDA reach T4; their opcodes 0/1/2 equal ALU modes 000/001/010.
        ctrl_d.alu_enable = 1'b1;
        ctrl_d.load_ac    = 1'b1;
        ctrl_d.alu_mode   = {1'b0, opcode[1:0]};
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= S_INIT;
      ctrl_q            <= '0;
      ctrl_q.clear_ar   <= 1'b1;
      ctrl_q.clear_pc   <= 1'b1;
      ctrl_q.clear_dr   <= 1'b1;
      ctrl_q.clear_ac   <= 1'b1;
      ctrl_q.clear_tr   <= 1'b1;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign load_ar       = ctrl_q.load_ar;
  assign load_pc       = ctrl_q.load_pc;
  assign load_dr       = ctrl_q.load_dr;
  assign load_ac       = ctrl_q.load_ac;
  assign load_ir       = ctrl_q.load_ir;
  assign load_tr       = ctrl_q.load_tr;
  assign clear_ar      = ctrl_q.clear_ar;
  assign clear_pc      = ctrl_q.clear_pc;
  assign clear_dr      = ctrl_q.clear_dr;
  assign clear_ac      = ctrl_q.clear_ac;
  assign clear_tr      = ctrl_q.clear_tr;
  assign inc_ar        = ctrl_q.inc_ar;
  assign inc_pc        = ctrl_q.inc_pc;
  assign inc_dr        = ctrl_q.inc_dr;
  assign inc_ac        = ctrl_q.inc_ac;
  assign inc_tr        = ctrl_q.inc_tr;
  assign memory_read   = ctrl_q.memory_read;
  assign memory_write  = ctrl_q.memory_write;
  assign bus_selectors = ctrl_q.bus_sel;
  assign alu_enable    = ctrl_q.alu_enable;
  assign alu_mode      = ctrl_q.alu_mode;

  always_comb begin
    bus_out = x_data;
    case (ctrl_q.bus_sel)
      3'd0: bus_out = x_data;
      3'd1: bus_out = {4'b0000, ar};
      3'd2: bus_out = {4'b0000, pc};
      3'd3: bus_out = dr;
      3'd4: bus_out = ac;
      3'd5: bus_out = ir;
      3'd6: bus_out = tr;
      3'd7: bus_out = memory_data;
      default: bus_out = x_data;
    endcase
  end

  logic [8:0] sum;

  always_comb begin
    sum        = {1'b0, ac} + {1'b0, dr};
    alu_result = ac;
    alu_e      = 1'b0;
    if (ctrl_q.alu_enable) begin
      case (ctrl_q.alu_mode)
        3'b000: alu_result = ac & dr;
        3'b001: {alu_e, alu_result} = sum;
        3'b010: alu_result = dr;
        3'b011: alu_result = ~ac;
`ifdef SHIFT_OPS_EN
        3'b100: begin
          alu_result = {1'b0, ac[7:1]};
          alu_e      = ac[0];
        end
        3'b101: begin
          alu_result = {ac[6:0], 1'b0};
          alu_e      = ac[7];
        end
`endif
        3'b110: alu_result = ac ^ dr;
        default: alu_result = ac;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bus_control.sv
// tb_alu_bus_control: runs directed and random instructions through alu_bus_control and
// compares every cycle's strobes, bus value and ALU value against an instruction-level model.
module tb_alu_bus_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ir, ac, dr, tr, x_data, memory_data;
  logic [3:0] ar, pc;
  logic [7:0] bus_out, alu_result;
  logic       alu_e;
  logic       load_ar, load_pc, load_dr, load_ac, load_ir, load_tr;
  logic       clear_ar, clear_pc, clear_dr, clear_ac, clear_tr;
  logic       inc_ar, inc_pc, inc_dr, inc_ac, inc_tr;
  logic       memory_read, memory_write;
  logic [2:0] bus_selectors;
  logic       alu_enable;
  logic [2:0] alu_mode;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  alu_bus_control dut (
    .clock(clock), .reset(reset),
    .ir(ir), .ac(ac), .dr(dr), .tr(tr), .x_data(x_data), .memory_data(memory_data),
    .ar(ar), .pc(pc),
    .bus_out(bus_out), .alu_result(alu_result), .alu_e(alu_e),
    .load_ar(load_ar), .load_pc(load_pc), .load_dr(load_dr), .load_ac(load_ac),
    .load_ir(load_ir), .load_tr(load_tr),
    .clear_ar(clear_ar), .clear_pc(clear_pc), .clear_dr(clear_dr), .clear_ac(clear_ac),
    .clear_tr(clear_tr),
    .inc_ar(inc_ar), .inc_pc(inc_pc), .inc_dr(inc_dr), .inc_ac(inc_ac), .inc_tr(inc_tr),
    .memory_read(memory_read), .memory_write(memory_write),
    .bus_selectors(bus_selectors), .alu_enable(alu_enable), .alu_mode(alu_mode)
  );

  // Named bit positions of the observed control word.
  localparam logic [24:0] LD_AR = 25'(1) << 24;
  localparam logic [24:0] LD_PC = 25'(1) << 23;
  localparam logic [24:0] LD_DR = 25'(1) << 22;
  localparam logic [24:0] LD_AC = 25'(1) << 21;
  localparam logic [24:0] LD_IR = 25'(1) << 20;
  localparam logic [24:0] CL_AR = 25'(1) << 18;
  localparam logic [24:0] CL_PC = 25'(1) << 17;
  localparam logic [24:0] CL_DR = 25'(1) << 16;
  localparam logic [24:0] CL_AC = 25'(1) << 15;
  localparam logic [24:0] CL_TR = 25'(1) << 14;
  localparam logic [24:0] IN_PC = 25'(1) << 12;
  localparam logic [24:0] IN_AC = 25'(1) << 10;
  localparam logic [24:0] MRD   = 25'(1) << 8;
  localparam logic [24:0] MWR   = 25'(1) << 7;
  localparam logic [24:0] AEN   = 25'(1) << 6;
  localparam logic [24:0] CL_ALL = CL_AR | CL_PC | CL_DR | CL_AC | CL_TR;

  logic [24:0] obs;
  assign obs = {load_ar, load_pc, load_dr, load_ac, load_ir, load_tr,
                clear_ar, clear_pc, clear_dr, clear_ac, clear_tr,
                inc_ar, inc_pc, inc_dr, inc_ac, inc_tr,
                memory_read, memory_write, alu_enable, bus_selectors, alu_mode};

  logic [24:0] exp_q[$];

  function automatic logic [24:0] sel(input int s);
    return 25'(s) << 3;
  endfunction

  function automatic logic [24:0] mode(input int m);
    return 25'(m);
  endfunction

  // Per-cycle expected control words for one whole instruction.
  function automatic void build_exp(input logic [3:0] op);
    exp_q.delete();
    exp_q.push_back(LD_AR | sel(2));
    exp_q.push_back(MRD | sel(7) | LD_IR | IN_PC);
    exp_q.push_back(sel(5) | LD_AR);
    case (op)
      4'h0, 4'h1, 4'h2: begin
        exp_q.push_back(MRD | sel(7) | LD_DR);
        exp_q.push_back(AEN | LD_AC | mode(int'(op)));
      end
      4'h3: exp_q.push_back(sel(4) | MWR);
      4'h4: exp_q.push_back(sel(1) | LD_PC);
      4'h6: exp_q.push_back(CL_AC);
      4'h7: exp_q.push_back(AEN | mode(3) | LD_AC);
      4'h8: exp_q.push_back(IN_AC);
`ifdef SHIFT_OPS_EN
      4'h9: exp_q.push_back(AEN | mode(4) | LD_AC);
      4'hA: exp_q.push_back(AEN | mode(5) | LD_AC);
`endif
      default: exp_q.push_back(25'd0);
    endcase
  endfunction

  function automatic logic [7:0] bus_ref(input logic [2:0] s);
    case (s)
      3'd0: return x_data;
      3'd1: return 8'(ar);
      3'd2: return 8'(pc);
      3'd3: return dr;
      3'd4: return ac;
      3'd5: return ir;
      3'd6: return tr;
      default: return memory_data;
    endcase
  endfunction

  // Returns {e, result} from arithmetic on the operand values.
  function automatic logic [8:0] alu_ref(input logic en, input logic [2:0] m);
    int a, d, s;
    a = int'(ac);
    d = int'(dr);
    if (!en) return {1'b0, ac};
    case (m)
      3'd0: return {1'b0, ac & dr};
      3'd1: begin s = a + d; return {s >= 256, 8'(s % 256)}; end
      3'd2: return {1'b0, dr};
      3'd3: return {1'b0, 8'(255 - a)};
`ifdef SHIFT_OPS_EN
      3'd4: return {(a % 2) == 1, 8'(a / 2)};
      3'd5: return {a >= 128, 8'((a * 2) % 256)};
`endif
      3'd6: return {1'b0, ac ^ dr};
      default: return {1'b0, ac};
    endcase
  endfunction

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_mis++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Call #1 after the edge that entered T0. Checks up to max_cyc cycles; when
  // truncated it returns at the falling edge inside the last checked cycle.
  task automatic run_instr(input logic [7:0] ir_v, input logic [7:0] ac_v,
                           input logic [7:0] dr_v, input int max_cyc);
    logic [24:0] v;
    logic [8:0]  a;
    int n;
    ir = ir_v; ac = ac_v; dr = dr_v;
    ar = ir_v[3:0];
    pc = 4'($urandom);
    tr = 8'($urandom);
    x_data = 8'($urandom);
    memory_data = 8'($urandom);
    build_exp(ir_v[7:4]);
    n = exp_q.size();
    if (max_cyc < n) n = max_cyc;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      v = exp_q[i];
      a = alu_ref(v[6], v[2:0]);
      check($sformatf("ctrl ir=%h cyc=%0d", ir_v, i), obs, v);
      check($sformatf("bus ir=%h cyc=%0d", ir_v, i), 25'(bus_out), 25'(bus_ref(v[5:3])));
      check($sformatf("alu ir=%h ac=%h dr=%h cyc=%0d", ir_v, ac_v, dr_v, i),
            25'({alu_e, alu_result}), 25'(a));
      if (i < n - 1 || n == exp_q.size()) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ir = 8'h00; ac = 8'h00; dr = 8'h00; tr = 8'h00;
    x_data = 8'h00; memory_data = 8'h00; ar = 4'h0; pc = 4'h0;

    // Reset takes effect without a clock edge and holds INIT.
    #2 reset = 1'b0;
    #1 check("reset_async", obs, CL_ALL);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_hold", obs, CL_ALL);
    reset = 1'b1;
    #1 check("reset_release_init", obs, CL_ALL);
    @(posedge clock);
    #1;

    // Directed instructions.
    run_instr(8'h15, 8'hF0, 8'h20, 99);   // ADD with carry out
    run_instr(8'h37, 8'h5C, 8'h11, 99);   // STA
    run_instr(8'h4A, 8'h33, 8'h44, 99);   // BUN
    run_instr(8'h90, 8'h81, 8'h00, 99);   // SHR
    run_instr(8'hA0, 8'hC3, 8'h00, 99);   // SHL
    run_instr(8'h03, 8'hAA, 8'h0F, 99);   // AND
    run_instr(8'h25, 8'h00, 8'h7E, 99);   // LDA
    run_instr(8'h70, 8'h96, 8'h00, 99);   // CMA
    run_instr(8'h60, 8'h96, 8'h00, 99);   // CLA
    run_instr(8'h80, 8'hFF, 8'h00, 99);   // INC
    run_instr(8'h50, 8'h12, 8'h34, 99);   // NOP

    // Random instructions, HLT excluded so the run keeps going.
    for (int k = 0; k < 40; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      run_instr({op, 4'($urandom)}, 8'($urandom), 8'($urandom), 99);
    end

    // Reset dropped in the middle of T3 of an ADD.
    run_instr(8'h19, 8'h77, 8'h99, 4);
    #2 reset = 1'b0;
    #1 check("reset_mid_t3", obs, CL_ALL);
    @(negedge clock);
    reset = 1'b1;
    #1 check("reset_mid_t3_init", obs, CL_ALL);
    @(posedge clock);
    #1;
    run_instr(8'h15, 8'h01, 8'h02, 99);

    // HLT: four cycles, then all strobes stay low until reset.
    run_instr(8'hF0, 8'h42, 8'h24, 99);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check($sformatf("halt cyc=%0d", k), obs, 25'd0);
    end
    #2 reset = 1'b0;
    #1 check("halt_reset", obs, CL_ALL);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    run_instr(8'h1F, 8'h80, 8'h80, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
